// File: rtl/instr_queue.sv
// First-word-fall-through instruction queue feeding the processor IR.
// The head entry is visible on din before the pop edge, and NOP_WORD is shown when the queue is empty.
module instr_queue #(
  parameter int         DEPTH    = 16,
  parameter logic [8:0] NOP_WORD = 9'b000_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [8:0]               wr_data,
  input  logic                     fetch,
  input  logic                     clr,
  output logic [8:0]               din,
  output logic                     din_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign din_valid = ~empty;
  assign din       = empty ? NOP_WORD : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A full queue still accepts a push when the same edge pops, because a slot frees up.
  assign push = wr_en & (~full | fetch);
  assign pop  = fetch & ~empty;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d     = count_q + CW'(push) - CW'(pop);
      overflow_d  = overflow_q  | (wr_en & full & ~fetch);
      underflow_d = underflow_q | (fetch & empty);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; count and the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of 9-bit instruction entries; SHALL be a power of two, at least 2.
REQ-002 Parameter NOP_WORD, default 9'b000_000_000, meaning the word driven on din when empty (DISP r0).
REQ-003 clk  input  1  meaning single clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  meaning reset; asynchronous and active-high.
REQ-005 wr_en  input  1  meaning push request, sampled at posedge clk.
REQ-006 wr_data  input  9  meaning instruction word to push, format {opcode[8:6], rX[5:3], rY[2:0]}.
REQ-007 fetch  input  1  meaning pop request; connected to processor tick[0].
REQ-008 clr  input  1  meaning synchronous flush.
REQ-009 din  output  9  meaning head entry presented to processor IR.
REQ-010 din_valid  output  1  meaning din holds a real queued instruction.
REQ-011 full  output  1  meaning count == DEPTH.
REQ-012 empty  output  1  meaning count == 0.
REQ-013 count  output  $clog2(DEPTH)+1  meaning occupied entries.
REQ-014 overflow  output  1  meaning sticky flag, push rejected because full.
REQ-015 underflow  output  1  meaning sticky flag, fetch made while empty.

Function
REQ-016 The queue SHALL be first-word-fall-through: din SHALL be combinationally equal to the head entry whenever empty is 0, so the processor latches it on the same edge that fetch pops it.
REQ-017 When empty is 1, din SHALL equal NOP_WORD and din_valid SHALL be 0.
REQ-018 Push: when wr_en=1 and full=0 at posedge, wr_data SHALL be written at wr_ptr, wr_ptr SHALL advance by 1 modulo DEPTH, and count SHALL increment.
REQ-019 Pop: when fetch=1 and empty=0 at posedge, rd_ptr SHALL advance by 1 modulo DEPTH, and count SHALL decrement.
REQ-020 Push and pop in the same cycle, neither full nor empty: both SHALL occur and count SHALL be unchanged.
REQ-021 Push and pop in the same cycle while full: both SHALL occur, count SHALL stay DEPTH, and overflow SHALL NOT set.
REQ-022 Push and pop in the same cycle while empty: the push SHALL occur and the pop SHALL be ignored (no bypass), count SHALL become 1, underflow SHALL set, and the processor SHALL latch NOP_WORD.
REQ-023 Push while full without pop: data SHALL be dropped, pointers and count SHALL be unchanged, and overflow SHALL set.
REQ-024 Fetch while empty without push: the queue state SHALL be unchanged and underflow SHALL set.
REQ-025 Pointer wrap: rd_ptr and wr_ptr SHALL wrap from DEPTH-1 to 0 with no loss or reordering of entries.
REQ-026 clr=1 at posedge SHALL zero rd_ptr, wr_ptr, count, overflow and underflow.
REQ-027 clr SHALL have priority over a push or pop in the same cycle.
REQ-028 The storage array contents SHALL NOT need clearing on clr.
REQ-029 Once set, overflow and underflow SHALL stay 1 until clr or rst.
REQ-030 full, empty and din_valid SHALL be decoded from registered count only, with no combinational path from wr_en or fetch.

Reset
REQ-031 On rst assertion, rd_ptr, wr_ptr, count, overflow and underflow SHALL go to 0 immediately without waiting for a clock edge.
REQ-032 Reset values of the outputs SHALL be: din=NOP_WORD, din_valid=0, empty=1, full=0, count=0, overflow=0, underflow=0.
REQ-033 If rst asserts mid-operation (concurrent push or pop), the operation SHALL be discarded, and all queued entries SHALL be treated as lost.
REQ-034 Storage array contents SHALL be don't-care after reset.
REQ-035 The first push SHALL be accepted on the first posedge after rst deasserts.

Verification
REQ-036 The bench SHALL cover basic order: push 9'o711 (MOV_I r1,...), 9'o123, then 9'o010; pulse fetch three times -> din shows 9'o711, 9'o123, 9'o010 in that order, then empty=1 and din=NOP_WORD.
REQ-037 The bench SHALL cover fill and overflow: push 17 words 0..16 with DEPTH=16 -> full=1 after the 16th push, the 17th word is dropped, overflow=1, count=16, and draining yields 0..15.
REQ-038 The bench SHALL cover wrap: push 10 words, pop 8, then push 12 words -> count=14, and the pop order continues sequentially across the pointer wrap.
REQ-039 The bench SHALL cover simultaneous push and pop at the boundaries:
- Full with wr_en=fetch=1 -> count stays 16 and overflow stays 0.
- Empty with wr_en=fetch=1 -> count=1, underflow=1, and the pushed word is at the head.
REQ-040 The bench SHALL cover reset and flush:
- Assert rst between clock edges with count=5 -> outputs take their reset values immediately.
- clr coinciding with a push -> count=0 and overflow=underflow=0.
